// File: rtl/simon_stream_adapter_if.sv
// Byte-stream, core-strobe and result-stream signals of the simon stream adapter.
// master = the adapter itself, slave = the environment around it.
interface simon_stream_adapter_if;
    logic [7:0] i_byte;
    logic       i_valid;
    logic       o_ready;
    logic       o_shift;
    logic [3:0] o_data;
    logic [3:0] i_core_data;
    logic [7:0] o_res_byte;
    logic       o_res_valid;
    logic       i_res_ready;
    logic       o_busy;

    modport master (
        input  i_byte, i_valid, i_core_data, i_res_ready,
        output o_ready, o_shift, o_data, o_res_byte, o_res_valid, o_busy
    );

    modport slave (
        output i_byte, i_valid, i_core_data, i_res_ready,
        input  o_ready, o_shift, o_data, o_res_byte, o_res_valid, o_busy
    );
endinterface

// File: rtl/simon_stream_adapter.sv
// Feeds key/plaintext bytes into the nibble-serial simon core, waits out its rounds,
// then shifts the ciphertext back out as a byte stream.
module simon_stream_adapter #(
    parameter int LOAD_BYTES = 12,
    parameter int RUN_CYCLES = 32,
    parameter int OUT_BYTES  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    simon_stream_adapter_if.master        bus
);
    localparam int BW = $clog2(LOAD_BYTES + 1);
    localparam int RW = $clog2(RUN_CYCLES + 1);
    localparam int OW = $clog2(OUT_BYTES + 1);
    localparam int NW = $clog2(2 + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_e;

    state_e         state_q, state_d;
    logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]  run_cnt_q, run_cnt_d;
    logic [OW-1:0]  out_cnt_q, out_cnt_d;
    logic [NW-1:0]  nib_cnt_q, nib_cnt_d;
    logic [3:0]     nib_q, nib_d;
    logic           shift_q, shift_d;
    logic [3:0]     data_q, data_d;
    logic [7:0]     res_byte_q, res_byte_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           live_q;
    logic           ready;
    logic           accept;

    // LOAD: nib_cnt counts nibbles of the current byte already placed on o_data.
    // UNLOAD: nib_cnt counts nibbles captured for the current result byte.
    assign ready = live_q
                 && (state_q == IDLE || state_q == LOAD)
                 && (nib_cnt_q != NW'(1))
                 && (byte_cnt_q < BW'(LOAD_BYTES));
    assign accept = ready && bus.i_valid;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        run_cnt_d   = run_cnt_q;
        out_cnt_d   = out_cnt_q;
        nib_cnt_d   = nib_cnt_q;
        nib_d       = nib_q;
        res_byte_d  = res_byte_q;
        res_valid_d = res_valid_q;
        shift_d     = 1'b0;
        data_d      = 4'h0;

        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    state_d    = LOAD;
                    shift_d    = 1'b1;
                    data_d     = bus.i_byte[7:4];
                    nib_d      = bus.i_byte[3:0];
                    nib_cnt_d  = NW'(1);
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end else if (nib_cnt_q == NW'(1)) begin
                    shift_d   = 1'b1;
                    data_d    = nib_q;
                    nib_cnt_d = NW'(2);
                end else if (nib_cnt_q == NW'(2) && byte_cnt_q == BW'(LOAD_BYTES)) begin
                    state_d    = RUN;
                    nib_cnt_d  = '0;
                    byte_cnt_d = '0;
                end else begin
                    nib_cnt_d = '0;
                end
            end
            RUN: begin
                if (run_cnt_q == RW'(RUN_CYCLES - 1)) begin
                    state_d   = UNLOAD;
                    run_cnt_d = '0;
                    shift_d   = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (res_valid_q) begin
                    // Stalled result: shift stays low and the byte is left untouched.
                    if (bus.i_res_ready) begin
                        res_valid_d = 1'b0;
                        if (out_cnt_q == OW'(OUT_BYTES - 1)) begin
                            state_d   = IDLE;
                            out_cnt_d = '0;
                        end else begin
                            out_cnt_d = out_cnt_q + 1'b1;
                            shift_d   = 1'b1;
                        end
                    end
                end else if (shift_q) begin
                    if (nib_cnt_q == '0) begin
                        nib_d     = bus.i_core_data;
                        nib_cnt_d = NW'(1);
                        shift_d   = 1'b1;
                    end else begin
                        res_byte_d  = {nib_q, bus.i_core_data};
                        res_valid_d = 1'b1;
                        nib_cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            run_cnt_q   <= '0;
            out_cnt_q   <= '0;
            nib_cnt_q   <= '0;
            nib_q       <= '0;
            shift_q     <= 1'b0;
            data_q      <= '0;
            res_byte_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            run_cnt_q   <= run_cnt_d;
            out_cnt_q   <= out_cnt_d;
            nib_cnt_q   <= nib_cnt_d;
            nib_q       <= nib_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            res_byte_q  <= res_byte_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            live_q      <= 1'b1;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_shift     = shift_q;
    assign bus.o_data      = data_q;
    assign bus.o_res_byte  = res_byte_q;
    assign bus.o_res_valid = res_valid_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_simon_stream_adapter.sv
// Self-checking bench for simon_stream_adapter: table vectors, reset aborts and
// random operations against a core model that absorbs 2*LB nibbles then emits 2*OB.
module tb_simon_stream_adapter;
    localparam int LB = 12;
    localparam int RC = 32;
    localparam int OB = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    simon_stream_adapter_if bus ();

    simon_stream_adapter #(
        .LOAD_BYTES(LB),
        .RUN_CYCLES(RC),
        .OUT_BYTES (OB)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    // Core model: counts shift edges; after the load nibbles it emits core_src in order.
    logic [3:0] core_src [2*OB];
    int shift_edges = 0;
    int op_base     = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)        shift_edges <= 0;
        else if (bus.o_shift) shift_edges <= shift_edges + 1;
    end

    always_comb begin
        int k;
        k = shift_edges - op_base - 2*LB;
        bus.i_core_data = (k >= 0 && k < 2*OB) ? core_src[k] : 4'h0;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic       s_ready, s_shift, s_rv, s_busy;
    logic [3:0] s_data;
    logic [7:0] s_rb;
    int         sh_cyc[$];
    logic [3:0] sh_dat[$];
    logic [7:0] op_bytes [LB];
    logic [7:0] exp_res  [OB];
    logic [7:0] got_res  [OB];

    typedef struct {
        logic [8*LB-1:0] bytes;
        logic [8*OB-1:0] nibs;
        logic [8*OB-1:0] exp;
        int              gap;
        int              stall_idx;
        int              stall_len;
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic abort_run();
        $display("FAIL abort: bounded wait expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "aborted");
    endtask

    // Sample outputs on the falling edge, then move to just after the next rising edge.
    task automatic tick();
        @(negedge i_clk);
        s_ready = bus.o_ready;
        s_shift = bus.o_shift;
        s_data  = bus.o_data;
        s_rv    = bus.o_res_valid;
        s_rb    = bus.o_res_byte;
        s_busy  = bus.o_busy;
        if (s_shift) begin
            sh_cyc.push_back(cyc);
            sh_dat.push_back(s_data);
        end
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_op();
        sh_cyc.delete();
        sh_dat.delete();
        op_base = shift_edges;
        bus.i_res_ready = 1'b1;
    endtask

    task automatic load_phase(input int gap);
        int budget;
        for (int b = 0; b < LB; b++) begin
            bus.i_valid = 1'b1;
            bus.i_byte  = op_bytes[b];
            budget = 0;
            do begin
                tick();
                budget++;
            end while (!s_ready && budget < 50);
            check("load_accept", s_ready, 1);
            if (!s_ready) abort_run();
            if (gap > 0) begin
                bus.i_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        // Junk byte held valid while the adapter is not ready: must never be consumed.
        bus.i_valid = 1'b1;
        bus.i_byte  = 8'hEE;
    endtask

    task automatic unload_phase(input int stall_idx, input int stall_len);
        int budget;
        int errs;
        logic [7:0] held;
        for (int r = 0; r < OB; r++) begin
            if (r == OB-1) bus.i_valid = 1'b0;
            bus.i_res_ready = (r != stall_idx);
            budget = 0;
            do begin
                tick();
                budget++;
            end while (!s_rv && budget < 4*RC + 50);
            check("res_valid_wait", s_rv, 1);
            if (!s_rv) abort_run();
            if (r == stall_idx) begin
                held = s_rb;
                errs = 0;
                for (int k = 0; k < stall_len; k++) begin
                    if (k > 0) tick();
                    if (!s_rv || s_shift || s_rb !== held) errs++;
                end
                check("stall_hold", errs, 0);
                bus.i_res_ready = 1'b1;
                tick();
                check("stall_release", {s_rv, s_rb}, {1'b1, held});
            end
            got_res[r] = s_rb;
        end
        tick();
        check("end_ready", s_ready, 1);
        check("end_busy", s_busy, 0);
        check("end_res_valid", s_rv, 0);
    endtask

    task automatic run_op(input int gap, input int stall_idx, input int stall_len);
        int errs;
        int period;
        start_op();
        load_phase(gap);
        unload_phase(stall_idx, stall_len);
        period = (gap + 1 < 2) ? 2 : gap + 1;
        check("shift_count", sh_cyc.size(), 2*(LB + OB));
        if (sh_cyc.size() == 2*(LB + OB)) begin
            errs = 0;
            for (int b = 0; b < LB; b++) begin
                if (sh_dat[2*b] !== op_bytes[b][7:4] || sh_dat[2*b+1] !== op_bytes[b][3:0]
                    || sh_cyc[2*b+1] != sh_cyc[2*b] + 1) errs++;
            end
            check("load_nibbles", errs, 0);
            check("load_span", sh_cyc[2*LB-1] - sh_cyc[0], (LB-1)*period + 1);
            check("run_len", sh_cyc[2*LB] - sh_cyc[2*LB-1] - 1, RC);
            errs = 0;
            for (int k = 2*LB; k < 2*(LB + OB); k++) if (sh_dat[k] !== 4'h0) errs++;
            check("unload_data_zero", errs, 0);
        end
        for (int r = 0; r < OB; r++) check("res_byte", got_res[r], exp_res[r]);
    endtask

    task automatic reset_abort(input string tag);
        bus.i_valid = 1'b0;
        #1 i_rst_n = 1'b0;
        #1;
        check({tag, "_outs"},
              {bus.o_shift, bus.o_data, bus.o_ready, bus.o_res_byte, bus.o_res_valid, bus.o_busy},
              16'h0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        check({tag, "_ready_back"}, s_ready, 1);
    endtask

    initial begin
        int budget;
        vecs[0] = '{96'h0102030405060708090A0B0C, 32'h961FA53C, 32'h961FA53C, 0, -1, 0};
        vecs[1] = '{96'hA55AC33C0FF0123456789ABC, 32'h13579BDF, 32'h13579BDF, 3, -1, 0};
        vecs[2] = '{96'hFF00FF00FF00FF00FF00FF00, 32'h0F0FF0F0, 32'h0F0FF0F0, 0, 1, 5};
        for (int k = 0; k < 2*OB; k++) core_src[k] = 4'h0;

        // Reset with i_valid high.
        bus.i_valid     = 1'b1;
        bus.i_byte      = 8'h5A;
        bus.i_res_ready = 1'b0;
        i_rst_n         = 1'b0;
        repeat (3) tick();
        check("rst_outs", {s_shift, s_data, s_ready, s_rb, s_rv, s_busy}, 16'h0);
        bus.i_valid = 1'b0;
        i_rst_n     = 1'b1;
        tick();
        check("rst_ready_pre", s_ready, 0);
        tick();
        check("rst_ready_post", s_ready, 1);

        for (int v = 0; v < 3; v++) begin
            for (int b = 0; b < LB; b++) op_bytes[b] = vecs[v].bytes[8*(LB-1-b) +: 8];
            for (int k = 0; k < 2*OB; k++) core_src[k] = vecs[v].nibs[4*(2*OB-1-k) +: 4];
            for (int r = 0; r < OB; r++) exp_res[r] = vecs[v].exp[8*(OB-1-r) +: 8];
            run_op(vecs[v].gap, vecs[v].stall_idx, vecs[v].stall_len);
        end

        // Abort during RUN, then a full operation.
        start_op();
        load_phase(0);
        repeat (10) tick();
        reset_abort("rst_run");
        run_op(0, -1, 0);

        // Abort after the first unload capture, then a full operation.
        start_op();
        load_phase(0);
        bus.i_res_ready = 1'b0;
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!s_shift && budget < 4*RC);
        check("unload_start", s_shift, 1);
        tick();
        reset_abort("rst_unload");
        run_op(0, -1, 0);

        // Random operations; expected result byte r = nibble 2r * 16 + nibble 2r+1.
        for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < LB; b++) op_bytes[b] = 8'($urandom);
            for (int k = 0; k < 2*OB; k++) core_src[k] = 4'($urandom_range(0, 15));
            for (int r = 0; r < OB; r++) exp_res[r] = 8'(core_src[2*r] * 16 + core_src[2*r+1]);
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, OB)),
                   int'($urandom_range(1, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
